// File: rtl/riscv_pkg.sv
// Shared RV32IM encodings for the execute stage: ALU ops, M-ext and branch funct3, forwarding and writeback selects.
// Latency: none (types and constants only).
// Backpressure: none.
package riscv_pkg;

    localparam int XLEN_P = 32;

    // ALU operation select driven by the decoder
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    // M-extension funct3
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // Branch funct3
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // Forwarding selects; 2'b11 falls back to the register file value
    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback source encodings carried down the pipe
    localparam logic [2:0] RES_ALU = 3'b000;
    localparam logic [2:0] RES_MEM = 3'b001;
    localparam logic [2:0] RES_PC4 = 3'b010;
    localparam logic [2:0] RES_LUI = 3'b011;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic [XLEN_P-1:0] alu_out;
        logic [XLEN_P-1:0] wdata;
        logic [XLEN_P-1:0] lui_auipc;
        logic [XLEN_P-1:0] pc_plus4;
        logic [2:0]        result_src;
        logic              mem_write;
        logic              reg_write;
        logic [4:0]        rd;
    } exmem_t;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned, with sign fix-up on the way out.
// Latency: start accepted in IDLE, STEPS cycles in BUSY, result valid during the single DONE cycle.
// Backpressure: none internally; the caller must hold i_start until done and stall its upstream while busy.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    // Operand magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude
    assign w_dvd_neg = i_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_signed & i_divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    // When the trial succeeds the true difference is below the divisor, so the low word is exact.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

    // FSM, step counter and partial remainder / quotient shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state == S_BUSY);
    assign o_done      = (r_state == S_DONE);
    assign o_quotient  = r_neg_q ? -r_quo : r_quo;
    assign o_remainder = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: forwarding, ALU, branch/jump resolution, LUI/AUIPC, MUL and iterative DIV/REM feeding EX/MEM.
// Latency: 1 cycle to M for ALU/MUL/special-case divides; DIV/REM result registered 34 cycles after entry.
// Backpressure: StallE holds IF/ID/EX for 33 cycles per divide while EX/MEM is loaded with bubbles.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  alu_ctrl_e       ALUControlE,
    input  logic            MulDivE,
    input  logic [2:0]      MulDivOpE,
    input  logic            ALUSrcE,
    input  logic            LuiE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            BranchE,
    input  logic [2:0]      Funct3E,
    input  logic            MemWriteE,
    input  logic            RegWriteE,
    input  logic [2:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            StallE,
    output logic [XLEN-1:0] ALUOutM,
    output logic [XLEN-1:0] MemWriteDataM,
    output logic [XLEN-1:0] LUI_or_AUIPCM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [2:0]      ResultSrcM,
    output logic            MemWriteM,
    output logic            RegWriteM,
    output logic [4:0]      RdM
);

    exmem_t            r_exmem;
    exmem_t            w_exmem_next;

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_fwd_b;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_alu_res;
    logic              w_br_cond;
    logic [XLEN-1:0]   w_pc_imm;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_lui_auipc;

    logic              w_mul_a_sgn;
    logic              w_mul_b_sgn;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_mul_prod;
    logic [XLEN-1:0]   w_mul_res;

    logic              w_div_signed;
    logic              w_div_is_rem;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_div_special;
    logic              w_div_req;
    logic              w_div_busy;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_quo;
    logic [XLEN-1:0]   w_div_rem;
    logic [XLEN-1:0]   w_div_res;
    logic [XLEN-1:0]   w_ex_res;

    // Operand forwarding from writeback or the EX/MEM register
    always_comb begin
        w_src_a = RD1E;
        w_fwd_b = RD2E;
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_exmem.alu_out;
            default: w_src_a = RD1E;
        endcase
        case (ForwardBE)
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = r_exmem.alu_out;
            default: w_fwd_b = RD2E;
        endcase
    end

    assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;

    // Integer ALU
    always_comb begin
        w_alu_res = '0;
        case (ALUControlE)
            ALU_ADD:  w_alu_res = w_src_a + w_src_b;
            ALU_SUB:  w_alu_res = w_src_a - w_src_b;
            ALU_AND:  w_alu_res = w_src_a & w_src_b;
            ALU_OR:   w_alu_res = w_src_a | w_src_b;
            ALU_XOR:  w_alu_res = w_src_a ^ w_src_b;
            ALU_SLL:  w_alu_res = w_src_a << w_src_b[4:0];
            ALU_SRL:  w_alu_res = w_src_a >> w_src_b[4:0];
            ALU_SRA:  w_alu_res = $signed(w_src_a) >>> w_src_b[4:0];
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
            default:  w_alu_res = '0;
        endcase
    end

    // Branch condition on the forwarded register operands
    always_comb begin
        w_br_cond = 1'b0;
        case (Funct3E)
            BR_EQ:   w_br_cond = (w_src_a == w_fwd_b);
            BR_NE:   w_br_cond = (w_src_a != w_fwd_b);
            BR_LT:   w_br_cond = ($signed(w_src_a) <  $signed(w_fwd_b));
            BR_GE:   w_br_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
            BR_LTU:  w_br_cond = (w_src_a <  w_fwd_b);
            BR_GEU:  w_br_cond = (w_src_a >= w_fwd_b);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_pc_imm    = PCE + ImmExtE;
    assign w_jalr_sum  = w_src_a + ImmExtE;
    assign PCTargetE   = JalrE ? (w_jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1}) : w_pc_imm;
    assign PCSrcE      = ~StallE & (JumpE | (BranchE & w_br_cond));
    assign w_lui_auipc = LuiE ? ImmExtE : w_pc_imm;

    // Multiplier: sign- or zero-extend to 2*XLEN, the low 2*XLEN bits of the product are exact either way
    assign w_mul_a_sgn = (MulDivOpE != MD_MULHU);
    assign w_mul_b_sgn = (MulDivOpE == MD_MUL) || (MulDivOpE == MD_MULH);
    assign w_mul_a     = {{XLEN{w_mul_a_sgn & w_src_a[XLEN-1]}}, w_src_a};
    assign w_mul_b     = {{XLEN{w_mul_b_sgn & w_fwd_b[XLEN-1]}}, w_fwd_b};
    assign w_mul_prod  = w_mul_a * w_mul_b;
    assign w_mul_res   = (MulDivOpE == MD_MUL) ? w_mul_prod[XLEN-1:0] : w_mul_prod[2*XLEN-1:XLEN];

    // Divide: zero divisor and signed overflow resolve without the iterative unit
    assign w_div_signed  = ~MulDivOpE[0];
    assign w_div_is_rem  = MulDivOpE[1];
    assign w_div_zero    = (w_fwd_b == '0);
    assign w_div_ovf     = w_div_signed && (w_src_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_fwd_b == '1);
    assign w_div_special = w_div_zero | w_div_ovf;
    assign w_div_req     = MulDivE & MulDivOpE[2] & ~w_div_special;

    div_iter #(
        .WIDTH (XLEN),
        .STEPS (DIV_STEPS)
    ) u_div (
        .clk         (clk),
        .rst         (reset),
        .i_start     (w_div_req),
        .i_signed    (w_div_signed),
        .i_dividend  (w_src_a),
        .i_divisor   (w_fwd_b),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    // The iterative result wins in DONE so late operand changes cannot select a special case
    always_comb begin
        w_div_res = '0;
        if (w_div_done) begin
            w_div_res = w_div_is_rem ? w_div_rem : w_div_quo;
        end else if (w_div_zero) begin
            w_div_res = w_div_is_rem ? w_src_a : '1;
        end else begin
            w_div_res = w_div_is_rem ? '0 : w_src_a;
        end
    end

    assign w_ex_res = MulDivE ? (MulDivOpE[2] ? w_div_res : w_mul_res) : w_alu_res;
    assign StallE   = ~reset & (w_div_busy | (w_div_req & ~w_div_done));

    assign w_exmem_next.alu_out    = w_ex_res;
    assign w_exmem_next.wdata      = w_fwd_b;
    assign w_exmem_next.lui_auipc  = w_lui_auipc;
    assign w_exmem_next.pc_plus4   = PCPlus4E;
    assign w_exmem_next.result_src = ResultSrcE;
    assign w_exmem_next.mem_write  = MemWriteE;
    assign w_exmem_next.reg_write  = RegWriteE;
    assign w_exmem_next.rd         = RdE;

    // EX/MEM register: bubble while stalled, data fields held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exmem <= '0;
        end else if (StallE) begin
            r_exmem.reg_write <= 1'b0;
            r_exmem.mem_write <= 1'b0;
            r_exmem.rd        <= '0;
        end else begin
            r_exmem <= w_exmem_next;
        end
    end

    assign ALUOutM       = r_exmem.alu_out;
    assign MemWriteDataM = r_exmem.wdata;
    assign LUI_or_AUIPCM = r_exmem.lui_auipc;
    assign PCPlus4M      = r_exmem.pc_plus4;
    assign ResultSrcM    = r_exmem.result_src;
    assign MemWriteM     = r_exmem.mem_write;
    assign RegWriteM     = r_exmem.reg_write;
    assign RdM           = r_exmem.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a queue of expected ALUOutM values.
// Latency: expects 1 cycle to M, 33 stall cycles per iterative divide.
// Backpressure: follows StallE by holding EX inputs while it is high.
module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    alu_ctrl_e   ALUControlE;
    logic        MulDivE;
    logic [2:0]  MulDivOpE;
    logic        ALUSrcE, LuiE, JumpE, JalrE, BranchE;
    logic [2:0]  Funct3E;
    logic        MemWriteE, RegWriteE;
    logic [2:0]  ResultSrcE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] PCTargetE;
    logic        PCSrcE, StallE;
    logic [31:0] ALUOutM, MemWriteDataM, LUI_or_AUIPCM, PCPlus4M;
    logic [2:0]  ResultSrcM;
    logic        MemWriteM, RegWriteM;
    logic [4:0]  RdM;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    execute_stage #(.XLEN(32), .DIV_STEPS(32)) dut (
        .clk(clk), .reset(reset),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .ALUControlE(ALUControlE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
        .ALUSrcE(ALUSrcE), .LuiE(LuiE), .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE),
        .Funct3E(Funct3E), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallE(StallE),
        .ALUOutM(ALUOutM), .MemWriteDataM(MemWriteDataM), .LUI_or_AUIPCM(LUI_or_AUIPCM),
        .PCPlus4M(PCPlus4M), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .RdM(RdM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_m(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=output expected=queued value (queue empty)", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, ALUOutM, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = 32'h100; PCPlus4E = 32'h104; ResultW = '0;
        RdE = 5'd1; ALUControlE = ALU_ADD; MulDivE = 1'b0; MulDivOpE = MD_MUL;
        ALUSrcE = 1'b0; LuiE = 1'b0; JumpE = 1'b0; JalrE = 1'b0; BranchE = 1'b0; Funct3E = 3'b000;
        MemWriteE = 1'b0; RegWriteE = 1'b1; ResultSrcE = RES_ALU; ForwardAE = FWD_RD; ForwardBE = FWD_RD;
    endtask

    task automatic run_alu(input string tag, input alu_ctrl_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        clear();
        ALUControlE = op; RD1E = a; RD2E = b;
        exp_q.push_back(exp);
        tick();
        chk_m(tag);
    endtask

    task automatic run_mul(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        clear();
        MulDivE = 1'b1; MulDivOpE = op; RD1E = a; RD2E = b;
        #1;
        chk({tag, "_nostall"}, 32'(StallE), 32'd0);
        exp_q.push_back(exp);
        tick();
        chk_m(tag);
    endtask

    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_stall, input bit fwd_wb);
        int n;
        clear();
        MulDivE = 1'b1; MulDivOpE = op; RD2E = b; RdE = 5'd5;
        if (fwd_wb) begin
            ForwardAE = FWD_WB; ResultW = a; RD1E = ~a;
        end else begin
            RD1E = a;
        end
        #1;
        n = 0;
        while (StallE === 1'b1 && n < 100) begin
            n++;
            tick();
            if (n == 1) begin
                chk({tag, "_bubble_rw"}, 32'(RegWriteM), 32'd0);
                chk({tag, "_bubble_rd"}, 32'(RdM), 32'd0);
            end
            if (fwd_wb) ResultW = $urandom;
            #1;
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        exp_q.push_back(exp);
        tick();
        chk_m(tag);
        chk({tag, "_rw"}, 32'(RegWriteM), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear();
        reset = 1'b1;
        #12;
        chk("rst_aluout", ALUOutM, 32'd0);
        chk("rst_regwrite", 32'(RegWriteM), 32'd0);
        chk("rst_pcplus4", PCPlus4M, 32'd0);
        chk("rst_stall", 32'(StallE), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD plus AUIPC value and store data
        RD1E = 32'd5; RD2E = 32'd7; RdE = 5'd3; PCE = 32'h1000; ImmExtE = 32'h2000;
        exp_q.push_back(32'd12);
        tick();
        chk_m("add");
        chk("add_rw", 32'(RegWriteM), 32'd1);
        chk("add_rd", 32'(RdM), 32'd3);
        chk("auipc", LUI_or_AUIPCM, 32'h3000);
        chk("wdata", MemWriteDataM, 32'd7);

        // Forward from M (prior ALUOutM=12) and from WB
        ForwardAE = FWD_MEM; RD1E = 32'hDEAD;
        exp_q.push_back(32'd19);
        tick();
        chk_m("fwd_mem");
        ForwardAE = FWD_WB; ResultW = 32'd100; ALUControlE = ALU_SUB; LuiE = 1'b1;
        exp_q.push_back(32'd93);
        tick();
        chk_m("fwd_wb_sub");
        chk("lui", LUI_or_AUIPCM, 32'h2000);

        run_alu("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_alu("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_alu("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_alu("srl_shamt", ALU_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
        run_alu("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);

        // Branches and JALR target, combinational
        clear();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; PCE = 32'h100; ImmExtE = 32'h20; BranchE = 1'b1;
        RegWriteE = 1'b0; Funct3E = BR_LT;
        #1;
        chk("blt_pcsrc", 32'(PCSrcE), 32'd1);
        chk("blt_target", PCTargetE, 32'h120);
        Funct3E = BR_LTU;
        #1;
        chk("bltu_pcsrc", 32'(PCSrcE), 32'd0);
        Funct3E = 3'b011;
        #1;
        chk("br_badf3", 32'(PCSrcE), 32'd0);
        BranchE = 1'b0; JumpE = 1'b1; JalrE = 1'b1; RD1E = 32'h203; ImmExtE = 32'h10;
        #1;
        chk("jalr_pcsrc", 32'(PCSrcE), 32'd1);
        chk("jalr_target", PCTargetE, 32'h212);
        tick();

        // Divides, back to back
        run_div("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_div("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        run_div("divu_10_0", MD_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        run_div("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
        run_div("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run_div("rem_m7_0", MD_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 1'b0);
        run_div("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_div("remu_big", MD_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 1'b0);
        run_div("div_min_2", MD_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b0);
        run_div("rem_7_m2", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);

        // Multiplies
        run_mul("mul_lo", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        run_mul("mulh_m1", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        run_mul("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_mul("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Reset in the middle of a divide
        clear();
        MulDivE = 1'b1; MulDivOpE = MD_DIV; RD1E = 32'd100; RD2E = 32'd3;
        #1;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_div_stall", 32'(StallE), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_stall", 32'(StallE), 32'd0);
        chk("abort_aluout", ALUOutM, 32'd0);
        chk("abort_rw", 32'(RegWriteM), 32'd0);
        chk("abort_pc4", PCPlus4M, 32'd0);
        chk("abort_wdata", MemWriteDataM, 32'd0);
        clear();
        RD1E = 32'd1; RD2E = 32'd1;
        #2;
        reset = 1'b0;
        exp_q.push_back(32'd2);
        tick();
        chk_m("post_reset_add");
        chk("post_reset_rw", 32'(RegWriteM), 32'd1);
        chk("post_reset_stall", 32'(StallE), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
